// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I decode stage: opcodes, ALU encodings,
// immediate formats and the registered decode bundle.
package decode_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;
    localparam int PC_W     = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_SUB  = 4'b0101,
        ALU_SRA  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SLT  = 4'b1100,
        ALU_SLTU = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     imm;
        logic                use_imm;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic [2:0]          funct3;
        logic                illegal;
    } dec_t;

    // alt selects SUB/SRA (instr[30]) where the encoding allows it.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32I immediate layout for the given format and
// sign-extends it from instr[31]. R-type has no immediate and yields zero.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides; the decoded bundle
// is computed combinationally from in_instr and captured on accept.
module decode_stage
    import decode_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [REG_AW-1:0]   rs1,
    output logic [REG_AW-1:0]   rs2,
    output logic [REG_AW-1:0]   rd,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     imm,
    output logic                use_imm,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jump,
    output logic [2:0]          out_funct3,
    output logic                illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    fmt_e            fmt;
    logic            legal;
    logic [XLEN-1:0] imm_w;
    dec_t            dec;
    logic            accept;

    dec_t            bundle_d, bundle_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            valid_d, valid_q;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Format depends on opcode alone, kept apart so imm_gen never loops back into decode.
    always_comb begin
        fmt = FMT_R;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_R;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_w)
    );

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.rd        = in_instr[11:7];
                dec.alu_op    = alu_from_f3(f3, in_instr[30]);
                dec.reg_write = 1'b1;
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && in_instr[30]);
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
            end
            OPC_LOAD: begin
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.alu_op    = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.alu_op    = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.mem_write = 1'b1;
                legal = f3 inside {3'b000, 3'b001, 3'b010};
            end
            OPC_BRANCH: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                legal = !(f3 inside {3'b010, 3'b011});
            end
            OPC_JAL: begin
                dec.rd        = in_instr[11:7];
                dec.alu_op    = ALU_ADD;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                legal = 1'b1;
            end
            OPC_JALR: begin
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.alu_op    = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                legal = (f3 == 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.rd        = in_instr[11:7];
                dec.alu_op    = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.imm       = imm_w;
        dec.funct3    = f3;
        dec.reg_write = dec.reg_write && (dec.rd != '0);
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Handshake: a beat moves on a side when its valid and ready are both high on the
    // rising edge. in_ready = !out_valid | out_ready, so an outgoing and incoming beat in
    // the same cycle replace the bundle with no bubble. flush drops the held bundle and
    // any same-cycle input but does not touch in_ready.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            pc_d     = in_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign rs1        = bundle_q.rs1;
    assign rs2        = bundle_q.rs2;
    assign rd         = bundle_q.rd;
    assign alu_op     = bundle_q.alu_op;
    assign imm        = bundle_q.imm;
    assign use_imm    = bundle_q.use_imm;
    assign reg_write  = bundle_q.reg_write;
    assign mem_read   = bundle_q.mem_read;
    assign mem_write  = bundle_q.mem_write;
    assign branch     = bundle_q.branch;
    assign jump       = bundle_q.jump;
    assign out_funct3 = bundle_q.funct3;
    assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a vector table streamed through the stage, a scoreboard
// queue checked on every output transfer, and hand-written stall/flush/reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        use_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [2:0]  out_funct3;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .alu_op     (alu_op),
        .imm        (imm),
        .use_imm    (use_imm),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .jump       (jump),
        .out_funct3 (out_funct3),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        ui, rw, mr, mw, br, jp;
        logic [2:0]  f3;
        logic        ill;
    } tb_dec_t;

    typedef struct {
        logic [31:0] instr;
        tb_dec_t     exp;
        tb_dec_t     mask;
    } vec_t;

    typedef struct {
        tb_dec_t     exp;
        tb_dec_t     mask;
        logic [31:0] pc;
        int          id;
    } sb_t;

    vec_t        vecs[$];
    sb_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] pc_ctr = 32'h1000;
    logic        rand_en = 1'b0;
    logic        ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink side: out_ready updated 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
    end

    function automatic tb_dec_t act_bundle();
        return tb_dec_t'({rs1, rs2, rd, alu_op, imm, use_imm, reg_write, mem_read,
                          mem_write, branch, jump, out_funct3, illegal});
    endfunction

    function automatic tb_dec_t ex(input int r1, input int r2, input int d, input int alu,
                                   input logic [31:0] im, input bit ui, input bit rw,
                                   input bit mr, input bit mw, input bit br, input bit jp,
                                   input int f3, input bit ill);
        tb_dec_t e;
        e.rs1 = 5'(r1); e.rs2 = 5'(r2); e.rd = 5'(d); e.alu = 4'(alu); e.imm = im;
        e.ui = ui; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jp = jp;
        e.f3 = 3'(f3); e.ill = ill;
        return e;
    endfunction

    function automatic tb_dec_t m_all();
        tb_dec_t m;
        m = '1;
        return m;
    endfunction

    function automatic tb_dec_t m_nof3();
        tb_dec_t m;
        m = '1; m.f3 = '0;
        return m;
    endfunction

    function automatic tb_dec_t m_br();
        tb_dec_t m;
        m = '1; m.alu = '0; m.ui = 1'b0;
        return m;
    endfunction

    function automatic tb_dec_t m_jal();
        tb_dec_t m;
        m = '1; m.alu = '0; m.ui = 1'b0; m.f3 = '0;
        return m;
    endfunction

    function automatic tb_dec_t m_ill();
        tb_dec_t m;
        m = '0; m.ill = 1'b1; m.rw = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.br = 1'b1; m.jp = 1'b1;
        return m;
    endfunction

    function automatic void add(input logic [31:0] instr, input tb_dec_t e, input tb_dec_t m);
        vec_t v;
        v.instr = instr; v.exp = e; v.mask = m;
        vecs.push_back(v);
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one instruction and wait (bounded) for the stage to take it.
    task automatic send(input logic [31:0] instr, input tb_dec_t e, input tb_dec_t m,
                        input int id);
        logic rdy;
        bit   done;
        sb_t  s;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_ctr;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy && !flush) begin
                s.exp = e; s.mask = m; s.pc = pc_ctr; s.id = id;
                exp_q.push_back(s);
                done = 1'b1;
            end
        end
        check(done, $sformatf("send%0d_accept", id), 64'(done), 64'd1);
        #1;
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    always @(negedge clk) begin
        sb_t     s;
        tb_dec_t a;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_output", 64'(out_pc), 64'd0);
            end else begin
                s = exp_q.pop_front();
                a = act_bundle();
                check(((a ^ s.exp) & s.mask) == '0, $sformatf("vec%0d_bundle", s.id),
                      64'(a), 64'(s.exp));
                check(out_pc == s.pc, $sformatf("vec%0d_pc", s.id), 64'(out_pc), 64'(s.pc));
            end
        end
    end

    task automatic drain(input string name);
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check(exp_q.size() == 0, name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        tb_dec_t     snap;
        logic [31:0] snap_pc;
        int          t0;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1;

        add(32'hFFF00093, ex(0, 0, 1, 4, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0, 0), m_all());
        add(32'h402081B3, ex(1, 2, 3, 5, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0), m_all());
        add(32'h422081B3, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'h0020A423, ex(1, 2, 0, 4, 32'h8, 1, 0, 0, 1, 0, 0, 2, 0), m_all());
        add(32'h123452B7, ex(0, 0, 5, 4, 32'h12345000, 1, 1, 0, 0, 0, 0, 0, 0), m_nof3());
        add(32'h00000000, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'hFFFFFFFF, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'h007302B3, ex(6, 7, 5, 4, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0), m_all());
        add(32'h40315093, ex(2, 0, 1, 7, 32'h403, 1, 1, 0, 0, 0, 0, 5, 0), m_all());
        add(32'h02311093, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'hFE208EE3, ex(1, 2, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0, 0), m_br());
        add(32'h0020A063, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'h008000EF, ex(0, 0, 1, 0, 32'h8, 0, 1, 0, 0, 0, 1, 0, 0), m_jal());
        add(32'h0080006F, ex(0, 0, 0, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0), m_jal());
        add(32'hFF822183, ex(4, 0, 3, 4, 32'hFFFFFFF8, 1, 1, 1, 0, 0, 0, 2, 0), m_all());
        add(32'h000290E7, ex(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), m_ill());
        add(32'h80000117, ex(0, 0, 2, 4, 32'h80000000, 1, 1, 0, 0, 0, 0, 0, 0), m_nof3());
        add(32'h00000013, ex(0, 0, 0, 4, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0), m_all());

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        check(act_bundle() == '0, "reset_bundle", 64'(act_bundle()), 64'd0);
        check(out_pc == '0, "reset_out_pc", 64'(out_pc), 64'd0);
        check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-throughput stream: one instruction accepted per cycle.
        t0 = cyc;
        foreach (vecs[i]) send(vecs[i].instr, vecs[i].exp, vecs[i].mask, i);
        check((cyc - t0) == vecs.size(), "throughput_cycles", 64'(cyc - t0), 64'(vecs.size()));
        drain("drain_stream");

        // Same table with random backpressure.
        rand_en = 1'b1;
        foreach (vecs[i]) send(vecs[i].instr, vecs[i].exp, vecs[i].mask, 100 + i);
        rand_en = 1'b0;
        ready_force = 1'b1;
        drain("drain_random");

        // Stall: held bundle stays stable, in_ready low, next instruction waits.
        ready_force = 1'b0;
        send(vecs[7].instr, vecs[7].exp, vecs[7].mask, 200);
        in_valid = 1'b1;
        in_instr = vecs[0].instr;
        in_pc    = pc_ctr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                snap    = act_bundle();
                snap_pc = out_pc;
            end else begin
                check(act_bundle() == snap, "stall_bundle_hold", 64'(act_bundle()), 64'(snap));
                check(out_pc == snap_pc, "stall_pc_hold", 64'(out_pc), 64'(snap_pc));
            end
            check(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'd0);
            check(out_valid == 1'b1, "stall_out_valid", 64'(out_valid), 64'd1);
        end
        ready_force = 1'b1;
        send(vecs[0].instr, vecs[0].exp, vecs[0].mask, 201);
        drain("drain_stall");

        // Flush while holding a bundle with an input offered.
        ready_force = 1'b0;
        send(vecs[3].instr, vecs[3].exp, vecs[3].mask, 300);
        in_valid = 1'b1;
        in_instr = vecs[1].instr;
        flush    = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b0, "flush_in_ready_held", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check(out_valid == 1'b0, "flush_held_dropped", 64'(out_valid), 64'd0);

        // Flush on an empty stage drops the offered input.
        in_valid = 1'b1;
        in_instr = vecs[4].instr;
        flush    = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "flush_in_ready_empty", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "flush_input_dropped", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset while a bundle is held.
        send(vecs[14].instr, vecs[14].exp, vecs[14].mask, 400);
        @(negedge clk);
        check(out_valid == 1'b1, "pre_reset_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(act_bundle() == '0, "rst_bundle", 64'(act_bundle()), 64'd0);
        check(out_pc == '0, "rst_out_pc", 64'(out_pc), 64'd0);
        ready_force = 1'b1;
        @(posedge clk);
        #1;

        // Stage still works after reset.
        send(vecs[16].instr, vecs[16].exp, vecs[16].mask, 500);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
